param_counter: RTL and testbench
================================

# param_counter

Parametrised up/down binary counter: next generation of the team's fixed 4-bit `counter`. It adds the following over the 4-bit block:
- configurable width and modulus
- direction control, synchronous clear and parallel load
- wrap or saturate mode
- built-in enable prescaler
- registered terminal-count pulse

It is the general counting primitive for timers, address generators and event counters in lab designs.

## Interface
- `WIDTH`, 4: counter width in bits, ≥1.
- `MAX_COUNT`, 2**WIDTH-1: highest count value, 1 ≤ MAX_COUNT ≤ 2**WIDTH-1.
- `PRESCALE`, 1: enabled cycles per count step, ≥1.
- `SATURATE`, 0: 0 = wrap at boundaries, 1 = hold at boundaries.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable, feeds prescaler.
- `up_dn`  in  1  1 = count up, 0 = count down.
- `clr`  in  1  synchronous clear.
- `load`  in  1  synchronous parallel load.
- `load_val`  in  WIDTH  value to load.
- `out`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal-count pulse, registered.

## Operation
- Reset (`rst`=1, asynchronous):
  - `out`=0, `tc`=0, prescaler count=0.
  - Takes effect immediately, independent of `clk`.
  - Holds while `rst` is high.
- Synchronous priority, highest first:
  1. `clr`: out←0, prescaler←0, tc←0.
  2. `load`: out←min(load_val, MAX_COUNT), prescaler←0, tc←0.
  3. step: fires when `en`=1 and the prescaler tick is set.
  4. hold: out unchanged, tc←0.
- Prescaler tick:
  - Prescaler counts cycles with `en`=1, range 0..PRESCALE-1.
  - tick=1 when `en`=1 and prescaler=PRESCALE-1; prescaler then returns to 0.
  - `en`=0 freezes the prescaler; the partial count is kept.
  - PRESCALE=1: tick=`en`.
- Step, up direction:
  - out<MAX_COUNT: out+1.
  - out=MAX_COUNT: 0 if SATURATE=0, held if SATURATE=1; tc←1.
- Step, down direction:
  - out>0: out-1.
  - out=0: MAX_COUNT if SATURATE=0, held if SATURATE=1; tc←1.
- `tc` is 1 only in the cycle after a boundary step. In saturate mode it pulses on every step attempted at the boundary.
- `up_dn` may change on any cycle; it is sampled only on step cycles.
- Arithmetic is WIDTH bits. Boundary compares use MAX_COUNT, never 2**WIDTH-1.
- An out-of-range state (>MAX_COUNT) is unreachable. If it occurs, the next up step goes to 0.

## Timing
- All outputs are registered; inputs sampled at edge N are visible on `out`/`tc` after edge N.
- Step latency from the first enabled cycle: PRESCALE edges.
- `tc` is coincident with the wrapped or held `out` value and lasts exactly one cycle.
- `rst` deassertion must meet recovery to `clk`. The first step can occur at the first edge after release.
- Reset mid-prescale discards the partial prescale count.

## Structure
- Shared package `counter_pkg`:
  - `DIR_UP`=1'b1, `DIR_DOWN`=1'b0.
  - `clamp` function: min(value, MAX_COUNT).
  - Width helper for the prescaler (clog2, minimum 1).
- Sub-module `tick_prescaler`:
  - Parameter: PRESCALE.
  - Ports: clk, rst, en, sync_clr, tick.
  - Instantiated once.
  - sync_clr driven by `clr`|`load`.
- Top level holds the count register, priority mux and `tc` register.

## Test plan
- Reset mid-count (defaults, en=1, up): count to 5, pulse `rst` between edges. Required: out=0 and tc=0 immediately; after release, out=1 at the first edge.
- Wrap up (MAX_COUNT=9, PRESCALE=1): from out=8. Required: edges give 9, 0, 1; tc=1 only in the cycle out=0.
- Saturate down (SATURATE=1, MAX_COUNT=9): up_dn=0 from out=1 for 3 edges. Required: out 0, 0, 0; tc sequence 0, 1, 1.
- Load clamp and priority (MAX_COUNT=9): load=1, load_val=12, en=1. Required: out=9, tc=0. Then clr=1 with load=1, load_val=3. Required: out=0.
- Prescaler (PRESCALE=3): en=1 continuously. Required: out increments on every 3rd edge (0→1 at edge 3, 1→2 at edge 6). Drop en for 2 cycles after 1 enabled cycle. Required: the next step comes 2 enabled cycles after re-enable.
- Down wrap (MAX_COUNT=5, SATURATE=0): from out=0, up_dn=0, step. Required: out=5, tc=1 for one cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// ============================================================================
//  Module   : counter_pkg
//  Purpose  : Shared constants and helpers for the parametrised counter family.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic [31:0] clamp(input logic [31:0] value,
                                          input logic [31:0] max_count);
        return (value > max_count) ? max_count : value;
    endfunction

    // Prescaler register width; a 1-bit register is kept even when PRESCALE=1.
    function automatic int prescale_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
//  Module   : tick_prescaler
//  Purpose  : Divides enabled cycles by PRESCALE and emits a one-cycle tick.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int                PW      = prescale_width(PRESCALE);
    localparam logic [PW-1:0]     C_LAST  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]     C_ONE   = PW'(1);

    logic [PW-1:0] r_cnt;

    // With PRESCALE=1 the register never leaves zero, so tick collapses to en.
    assign tick = en && (r_cnt == C_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (sync_clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : (r_cnt + C_ONE);
        end
    end

endmodule

`default_nettype wire

// File: rtl/param_counter.sv
// ============================================================================
//  Module   : param_counter
//  Purpose  : Up/down counter with modulus, wrap/saturate, load, clear,
//             enable prescaler and registered terminal-count pulse.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module param_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = (1 << WIDTH) - 1,
    parameter int PRESCALE  = 1,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             w_tick;
    logic             w_sync_clr;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_step_val;
    logic             w_step_tc;

    assign w_sync_clr     = clr | load;
    assign w_load_clamped = WIDTH'(clamp(32'(load_val), 32'(MAX_COUNT)));

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync_clr (w_sync_clr),
        .tick     (w_tick)
    );

    // An out-of-range count (>MAX) recovers to 0 on the next up step.
    always_comb begin
        w_step_val = r_count;
        w_step_tc  = 1'b0;
        if (up_dn == DIR_UP) begin
            if (r_count >= C_MAX) begin
                w_step_tc  = 1'b1;
                w_step_val = ((SATURATE != 0) && (r_count == C_MAX)) ? r_count : '0;
            end else begin
                w_step_val = r_count + C_ONE;
            end
        end else begin
            if (r_count == '0) begin
                w_step_tc  = 1'b1;
                w_step_val = (SATURATE != 0) ? '0 : C_MAX;
            end else begin
                w_step_val = r_count - C_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped;
            r_tc    <= 1'b0;
        end else if (w_tick) begin
            r_count <= w_step_val;
            r_tc    <= w_step_tc;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign out = r_count;
    assign tc  = r_tc;

endmodule

`default_nettype wire

// File: tb/tb_param_counter.sv
// ============================================================================
//  Module   : tb_param_counter
//  Purpose  : Directed self-checking bench over five counter configurations.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_param_counter;

    logic       clk;
    logic       rst;
    logic       en    [5];
    logic       up_dn [5];
    logic       clr   [5];
    logic       load  [5];
    logic [3:0] lv    [5];
    logic [3:0] q     [5];
    logic       t     [5];

    int vectors;
    int miscompares;

    // u0 defaults, u1 mod-10 wrap, u2 mod-10 saturate, u3 prescale-3, u4 mod-6 wrap
    param_counter u0 (
        .clk(clk), .rst(rst), .en(en[0]), .up_dn(up_dn[0]), .clr(clr[0]),
        .load(load[0]), .load_val(lv[0]), .out(q[0]), .tc(t[0]));
    param_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(0)) u1 (
        .clk(clk), .rst(rst), .en(en[1]), .up_dn(up_dn[1]), .clr(clr[1]),
        .load(load[1]), .load_val(lv[1]), .out(q[1]), .tc(t[1]));
    param_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(1)) u2 (
        .clk(clk), .rst(rst), .en(en[2]), .up_dn(up_dn[2]), .clr(clr[2]),
        .load(load[2]), .load_val(lv[2]), .out(q[2]), .tc(t[2]));
    param_counter #(.WIDTH(4), .MAX_COUNT(15), .PRESCALE(3), .SATURATE(0)) u3 (
        .clk(clk), .rst(rst), .en(en[3]), .up_dn(up_dn[3]), .clr(clr[3]),
        .load(load[3]), .load_val(lv[3]), .out(q[3]), .tc(t[3]));
    param_counter #(.WIDTH(4), .MAX_COUNT(5), .PRESCALE(1), .SATURATE(0)) u4 (
        .clk(clk), .rst(rst), .en(en[4]), .up_dn(up_dn[4]), .clr(clr[4]),
        .load(load[4]), .load_val(lv[4]), .out(q[4]), .tc(t[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        for (int i = 0; i < 5; i++) begin
            en[i] = 1'b0; up_dn[i] = 1'b1; clr[i] = 1'b0; load[i] = 1'b0; lv[i] = 4'd0;
        end
        edge_step();
        edge_step();
        for (int i = 0; i < 5; i++) begin
            chk("reset_out", q[i], 4'd0);
            chk("reset_tc", {3'b0, t[i]}, 4'd0);
        end
        rst = 1'b0;

        // Reset mid-count on the default configuration
        en[0] = 1'b1;
        for (int i = 1; i <= 5; i++) edge_step();
        chk("u0_count5", q[0], 4'd5);
        rst = 1'b1;
        #1;
        chk("u0_async_rst_out", q[0], 4'd0);
        chk("u0_async_rst_tc", {3'b0, t[0]}, 4'd0);
        #2;
        rst = 1'b0;
        edge_step();
        chk("u0_first_after_rst", q[0], 4'd1);
        en[0] = 1'b0;

        // Wrap up at MAX_COUNT=9
        load[1] = 1'b1; lv[1] = 4'd8;
        edge_step();
        chk("u1_load8", q[1], 4'd8);
        load[1] = 1'b0; en[1] = 1'b1; up_dn[1] = 1'b1;
        edge_step();
        chk("u1_up9", q[1], 4'd9);
        chk("u1_up9_tc", {3'b0, t[1]}, 4'd0);
        edge_step();
        chk("u1_wrap0", q[1], 4'd0);
        chk("u1_wrap0_tc", {3'b0, t[1]}, 4'd1);
        edge_step();
        chk("u1_up1", q[1], 4'd1);
        chk("u1_up1_tc", {3'b0, t[1]}, 4'd0);

        // Load clamp, then clear beating load
        load[1] = 1'b1; lv[1] = 4'd12;
        edge_step();
        chk("u1_load_clamp", q[1], 4'd9);
        chk("u1_load_clamp_tc", {3'b0, t[1]}, 4'd0);
        clr[1] = 1'b1; lv[1] = 4'd3;
        edge_step();
        chk("u1_clr_over_load", q[1], 4'd0);
        clr[1] = 1'b0; load[1] = 1'b0; en[1] = 1'b0;

        // Saturate down at zero
        load[2] = 1'b1; lv[2] = 4'd1;
        edge_step();
        chk("u2_load1", q[2], 4'd1);
        load[2] = 1'b0; en[2] = 1'b1; up_dn[2] = 1'b0;
        edge_step();
        chk("u2_down0", q[2], 4'd0);
        chk("u2_down0_tc", {3'b0, t[2]}, 4'd0);
        edge_step();
        chk("u2_sat_a", q[2], 4'd0);
        chk("u2_sat_a_tc", {3'b0, t[2]}, 4'd1);
        edge_step();
        chk("u2_sat_b", q[2], 4'd0);
        chk("u2_sat_b_tc", {3'b0, t[2]}, 4'd1);
        en[2] = 1'b0;
        edge_step();
        chk("u2_idle_tc", {3'b0, t[2]}, 4'd0);

        // Prescaler of 3
        en[3] = 1'b1;
        edge_step(); chk("u3_e1", q[3], 4'd0);
        edge_step(); chk("u3_e2", q[3], 4'd0);
        edge_step(); chk("u3_e3", q[3], 4'd1);
        edge_step(); chk("u3_e4", q[3], 4'd1);
        edge_step(); chk("u3_e5", q[3], 4'd1);
        edge_step(); chk("u3_e6", q[3], 4'd2);
        edge_step(); chk("u3_part1", q[3], 4'd2);
        en[3] = 1'b0;
        edge_step(); edge_step();
        chk("u3_frozen", q[3], 4'd2);
        en[3] = 1'b1;
        edge_step(); chk("u3_reen1", q[3], 4'd2);
        edge_step(); chk("u3_reen2", q[3], 4'd3);
        chk("u3_tc", {3'b0, t[3]}, 4'd0);
        en[3] = 1'b0;

        // Down wrap at MAX_COUNT=5
        en[4] = 1'b1; up_dn[4] = 1'b0;
        edge_step();
        chk("u4_wrap5", q[4], 4'd5);
        chk("u4_wrap5_tc", {3'b0, t[4]}, 4'd1);
        en[4] = 1'b0;
        edge_step();
        chk("u4_hold5", q[4], 4'd5);
        chk("u4_hold5_tc", {3'b0, t[4]}, 4'd0);
        en[4] = 1'b1;
        edge_step();
        chk("u4_down4", q[4], 4'd4);
        chk("u4_down4_tc", {3'b0, t[4]}, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
